// File: rtl/panel_line_receiver.sv
// rtl/panel_line_receiver.sv - panel-side line capture and frame-memory drain
// Captures column words and the serial row address, then writes committed lines out through a ping-pong buffer.
module panel_line_receiver #(
    parameter int WORDS    = 40,
    parameter int ROWS     = 720,
    parameter int ROW_BITS = 10,
    parameter int ROW_PH0  = 21,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lrn,
    input  logic              col_start,
    input  logic              col_shift_en,
    input  logic [31:0]       pix_data,
    input  logic              row_data,
    input  logic              g2,
    input  logic              g1,
    input  logic              err_clr,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              row_done,
    output logic              short_err,
    output logic              overrun_err,
    output logic              row_err
);

    localparam logic [5:0]          LP_WORDS = 6'(WORDS);
    localparam logic [5:0]          LP_LAST  = 6'(WORDS - 1);
    localparam logic [5:0]          LP_SAT   = 6'd63;
    localparam logic [5:0]          LP_PH_LO = 6'(ROW_PH0);
    localparam logic [5:0]          LP_PH_HI = 6'(ROW_PH0 + ROW_BITS - 1);
    localparam logic [ROW_BITS-1:0] LP_ROWS  = ROW_BITS'(ROWS);
    localparam int                  SEL_W    = $clog2(ROW_BITS);

    typedef enum logic {ST_IDLE, ST_DRAIN} state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [5:0]          r_phase;
    logic [5:0]          r_beats;
    logic [5:0]          r_idx;
    logic [ROW_BITS-1:0] r_shift;
    logic [ROW_BITS-1:0] r_row;
    logic                r_invalid;
    logic                r_cap_bank;
    logic [31:0]         r_mem [0:1][0:WORDS-1];
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [31:0]         r_wr_data;
    logic                r_row_done;
    logic                r_short_err;
    logic                r_overrun_err;
    logic                r_row_err;

    logic [5:0]          w_phase;
    logic [5:0]          w_beat;
    logic [5:0]          w_idx_next;
    logic [SEL_W-1:0]    w_bit_sel;
    logic                w_row_phase;
    logic                w_store;
    logic                w_row_bad;
    logic                w_accept;
    logic                w_g1_idle;
    logic                w_short;
    logic                w_commit;
    logic                w_overrun;
    logic                w_last;
    logic [ADDR_W-1:0]   w_base;

    // col_start makes its own cycle phase 0 / beat 0, so same-cycle beats land at index 0
    assign w_phase     = (col_start || !lrn) ? 6'd0 : r_phase;
    assign w_beat      = col_start ? 6'd0 : r_beats;
    assign w_bit_sel   = SEL_W'(w_phase - LP_PH_LO);
    assign w_row_phase = lrn && (w_phase >= LP_PH_LO) && (w_phase <= LP_PH_HI);
    assign w_store     = lrn && col_shift_en && (w_beat < LP_WORDS);
    assign w_row_bad   = g2 && (r_shift >= LP_ROWS);
    assign w_accept    = r_wr_en && wr_ready;
    assign w_idx_next  = r_idx + 6'd1;
    assign w_base      = ADDR_W'(r_row) * ADDR_W'(WORDS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= 6'd0;
            r_beats <= 6'd0;
        end else if (!lrn) begin
            r_phase <= 6'd0;
            r_beats <= 6'd0;
        end else begin
            r_phase <= (w_phase == LP_SAT) ? LP_SAT : w_phase + 6'd1;
            if (col_shift_en) begin
                r_beats <= (w_beat == LP_SAT) ? LP_SAT : w_beat + 6'd1;
            end else begin
                r_beats <= w_beat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_cap_bank][w_beat] <= pix_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_row     <= '0;
            r_invalid <= 1'b0;
        end else begin
            if (w_row_phase) begin
                r_shift[w_bit_sel] <= row_data;
            end
            if (g2) begin
                r_row <= r_shift;
            end
            if (!lrn || w_g1_idle) begin
                r_invalid <= 1'b0;
            end else if (w_row_bad) begin
                r_invalid <= 1'b1;
            end
        end
    end

    // A new error event in the same cycle as err_clr keeps the flag set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_short_err   <= 1'b0;
            r_overrun_err <= 1'b0;
            r_row_err     <= 1'b0;
        end else begin
            r_short_err   <= w_short   || (r_short_err   && !err_clr);
            r_overrun_err <= w_overrun || (r_overrun_err && !err_clr);
            r_row_err     <= w_row_bad || (r_row_err     && !err_clr);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_g1_idle    = 1'b0;
        w_short      = 1'b0;
        w_commit     = 1'b0;
        w_overrun    = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_g1_idle = g1 && lrn;
                w_short   = w_g1_idle && (r_beats < LP_WORDS);
                w_commit  = w_g1_idle && !w_short && !r_invalid;
                if (w_commit) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_overrun = g1;
                w_last    = w_accept && (r_idx == LP_LAST);
                if (w_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // On commit the just-filled bank becomes the drain bank; its word 0 is preloaded so wr_en rises next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap_bank <= 1'b0;
            r_wr_en    <= 1'b0;
            r_idx      <= 6'd0;
            r_wr_addr  <= '0;
            r_wr_data  <= 32'd0;
            r_row_done <= 1'b0;
        end else begin
            r_row_done <= 1'b0;
            if (w_commit) begin
                r_cap_bank <= ~r_cap_bank;
                r_wr_en    <= 1'b1;
                r_idx      <= 6'd0;
                r_wr_addr  <= w_base;
                r_wr_data  <= r_mem[r_cap_bank][0];
            end else if (w_accept) begin
                if (w_last) begin
                    r_wr_en    <= 1'b0;
                    r_row_done <= 1'b1;
                end else begin
                    r_idx     <= w_idx_next;
                    r_wr_addr <= r_wr_addr + ADDR_W'(1);
                    r_wr_data <= r_mem[~r_cap_bank][w_idx_next];
                end
            end
        end
    end

    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign busy        = (r_state == ST_DRAIN);
    assign row_done    = r_row_done;
    assign short_err   = r_short_err;
    assign overrun_err = r_overrun_err;
    assign row_err     = r_row_err;

endmodule

// File: tb/tb_panel_line_receiver.sv
// tb/tb_panel_line_receiver.sv - panel_line_receiver bench with a queue-based line model
// Directed generator-timed lines plus randomized lines, compared against the model every cycle.
module tb_panel_line_receiver;

    localparam int WORDS    = 40;
    localparam int ROWS     = 720;
    localparam int ROW_BITS = 10;
    localparam int ROW_PH0  = 21;
    localparam int ADDR_W   = 16;

    logic              clk          = 1'b0;
    logic              rst          = 1'b0;
    logic              lrn          = 1'b0;
    logic              col_start    = 1'b0;
    logic              col_shift_en = 1'b0;
    logic [31:0]       pix_data     = 32'd0;
    logic              row_data     = 1'b0;
    logic              g2           = 1'b0;
    logic              g1           = 1'b0;
    logic              err_clr      = 1'b0;
    logic              wr_ready     = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              busy;
    logic              row_done;
    logic              short_err;
    logic              overrun_err;
    logic              row_err;

    int n_tests    = 0;
    int n_fail     = 0;
    int ready_mode = 1;
    int acc_cnt    = 0;
    int acc_first  = 0;
    int acc_last   = 0;
    int acc_gaps   = 0;
    int acc_ones   = 0;

    panel_line_receiver #(
        .WORDS(WORDS), .ROWS(ROWS), .ROW_BITS(ROW_BITS), .ROW_PH0(ROW_PH0), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .lrn(lrn), .col_start(col_start), .col_shift_en(col_shift_en),
        .pix_data(pix_data), .row_data(row_data), .g2(g2), .g1(g1), .err_clr(err_clr),
        .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .row_done(row_done), .short_err(short_err), .overrun_err(overrun_err), .row_err(row_err)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       wr_ready = 1'b0;
            1:       wr_ready = 1'b1;
            2:       wr_ready = ~wr_ready;
            default: wr_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Model state: the current line is a queue of stored words, a committed line is a copied queue plus a base address
    int          m_phase, m_beats, m_pos, m_base, ph;
    logic [9:0]  m_shift, m_row;
    bit          m_invalid, m_draining, m_done, m_short, m_ovr, m_rerr;
    bit          acc, g1_idle, short_c, commit, ovr, bad;
    logic [31:0] m_line[$];
    logic [31:0] m_dq[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_beats = 0; m_pos = 0; m_base = 0;
            m_shift = '0; m_row = '0; m_invalid = 0; m_draining = 0; m_done = 0;
            m_short = 0; m_ovr = 0; m_rerr = 0;
            m_line.delete();
            m_dq.delete();
        end else begin
            ph      = (col_start || !lrn) ? 0 : m_phase;
            acc     = m_draining && wr_ready;
            g1_idle = g1 && lrn && !m_draining;
            short_c = g1_idle && (m_beats < WORDS);
            commit  = g1_idle && !short_c && !m_invalid;
            ovr     = g1 && m_draining;
            bad     = g2 && (int'(m_shift) >= ROWS);
            m_done  = 0;
            if (acc) begin
                if (m_pos == WORDS - 1) begin
                    m_draining = 0;
                    m_done     = 1;
                end else begin
                    m_pos++;
                end
            end
            if (commit) begin
                m_dq       = m_line;
                m_base     = int'(m_row) * WORDS;
                m_pos      = 0;
                m_draining = 1;
            end
            m_short = short_c || (m_short && !err_clr);
            m_ovr   = ovr     || (m_ovr   && !err_clr);
            m_rerr  = bad     || (m_rerr  && !err_clr);
            if (g2) m_row = m_shift;
            if (!lrn || g1_idle) m_invalid = 0;
            else if (bad) m_invalid = 1;
            if (ph >= ROW_PH0 && ph < ROW_PH0 + ROW_BITS) m_shift[ph - ROW_PH0] = row_data;
            if (!lrn) begin
                m_line.delete();
                m_beats = 0;
                m_phase = 0;
            end else begin
                if (col_start) begin
                    m_line.delete();
                    m_beats = 0;
                end
                if (col_shift_en) begin
                    if (m_beats < WORDS) m_line.push_back(pix_data);
                    if (m_beats < 63) m_beats++;
                end
                m_phase = (ph < 63) ? ph + 1 : 63;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        chk("wr_en", 64'(wr_en), 64'(m_draining));
        chk("busy", 64'(busy), 64'(m_draining));
        chk("row_done", 64'(row_done), 64'(m_done));
        chk("short_err", 64'(short_err), 64'(m_short));
        chk("overrun_err", 64'(overrun_err), 64'(m_ovr));
        chk("row_err", 64'(row_err), 64'(m_rerr));
        if (m_draining) begin
            chk("wr_addr", 64'(wr_addr), 64'(ADDR_W'(m_base + m_pos)));
            chk("wr_data", 64'(wr_data), 64'(m_dq[m_pos]));
        end
        if (wr_en && wr_ready) begin
            if (acc_cnt == 0) acc_first = int'(wr_addr);
            else if (int'(wr_addr) != acc_last + 1) acc_gaps++;
            acc_last = int'(wr_addr);
            if (wr_data == 32'hFFFF_FFFF) acc_ones++;
            acc_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_acc();
        acc_cnt  = 0;
        acc_gaps = 0;
        acc_ones = 0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
    endtask

    // Phase p of a line is the p-th cycle counted from the col_start cycle
    task automatic send_line(input int row, input int nbeats, input int g2_ph, input int g1_ph,
                             input bit rnd, input int lrn_lo, input int lrn_hi);
        int last_p;
        last_p = g1_ph;
        if (nbeats - 1 > last_p) last_p = nbeats - 1;
        if (ROW_PH0 + ROW_BITS > last_p) last_p = ROW_PH0 + ROW_BITS;
        for (int p = 0; p <= last_p; p++) begin
            col_start    = (p == 0);
            col_shift_en = (p < nbeats);
            pix_data     = rnd ? 32'($urandom) : 32'hFFFF_FFFF;
            row_data     = (p >= ROW_PH0 && p < ROW_PH0 + ROW_BITS) ? 1'(row >> (p - ROW_PH0))
                                                                    : 1'($urandom_range(0, 1));
            g2           = (p == g2_ph);
            g1           = (p == g1_ph);
            lrn          = !(p >= lrn_lo && p <= lrn_hi);
            err_clr      = rnd && ($urandom_range(0, 15) == 0);
            tick();
        end
        col_start    = 1'b0;
        col_shift_en = 1'b0;
        g1           = 1'b0;
        g2           = 1'b0;
        err_clr      = 1'b0;
        lrn          = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", 64'(busy), 64'd0);
    endtask

    initial begin
        int row, nb, g2p, g1p, lo, hi, n;
        #2 rst = 1'b1;
        repeat (3) tick();
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_row_done", 64'(row_done), 64'd0);
        chk("rst_errs", 64'({short_err, overrun_err, row_err}), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        rst = 1'b0;
        lrn = 1'b1;
        ready_mode = 1;
        repeat (2) tick();

        reset_acc();
        send_line(5, 42, 31, 43, 0, -1, -1);
        wait_idle(200);
        repeat (2) tick();
        chk("t1_count", 64'(acc_cnt), 64'd40);
        chk("t1_first", 64'(acc_first), 64'd200);
        chk("t1_last", 64'(acc_last), 64'd239);
        chk("t1_gaps", 64'(acc_gaps), 64'd0);
        chk("t1_data", 64'(acc_ones), 64'd40);
        chk("t1_errs", 64'({short_err, overrun_err, row_err}), 64'd0);

        ready_mode = 2;
        reset_acc();
        send_line(5, 42, 31, 43, 1, -1, -1);
        wait_idle(300);
        repeat (2) tick();
        chk("t2_count", 64'(acc_cnt), 64'd40);
        chk("t2_first", 64'(acc_first), 64'd200);
        chk("t2_last", 64'(acc_last), 64'd239);
        chk("t2_gaps", 64'(acc_gaps), 64'd0);
        ready_mode = 1;

        reset_acc();
        send_line(719, 42, 31, 43, 0, -1, -1);
        wait_idle(200);
        repeat (2) tick();
        chk("t3_count", 64'(acc_cnt), 64'd40);
        chk("t3_first", 64'(acc_first), 64'd28760);
        chk("t3_last", 64'(acc_last), 64'd28799);
        reset_acc();
        send_line(720, 42, 31, 43, 0, -1, -1);
        repeat (3) tick();
        chk("t3_row_err", 64'(row_err), 64'd1);
        chk("t3_bad_count", 64'(acc_cnt), 64'd0);
        chk("t3_bad_busy", 64'(busy), 64'd0);
        pulse_clr();
        chk("t3_row_err_clr", 64'(row_err), 64'd0);

        reset_acc();
        send_line(9, 30, 31, 43, 1, -1, -1);
        tick();
        chk("t4_short_err", 64'(short_err), 64'd1);
        chk("t4_count", 64'(acc_cnt), 64'd0);
        chk("t4_busy", 64'(busy), 64'd0);
        pulse_clr();
        chk("t4_short_clr", 64'(short_err), 64'd0);

        ready_mode = 0;
        reset_acc();
        send_line(3, 42, 31, 43, 0, -1, -1);
        send_line(4, 42, 31, 43, 1, -1, -1);
        chk("t5_overrun", 64'(overrun_err), 64'd1);
        chk("t5_busy", 64'(busy), 64'd1);
        chk("t5_count0", 64'(acc_cnt), 64'd0);
        ready_mode = 1;
        wait_idle(200);
        repeat (60) tick();
        chk("t5_count", 64'(acc_cnt), 64'd40);
        chk("t5_first", 64'(acc_first), 64'd120);
        chk("t5_last", 64'(acc_last), 64'd159);
        pulse_clr();

        reset_acc();
        send_line(7, 42, 31, 43, 1, -1, -1);
        n = 0;
        while (acc_cnt < 10 && n < 100) begin
            tick();
            n++;
        end
        chk("t6_reach10", 64'(acc_cnt >= 10), 64'd1);
        rst = 1'b1;
        tick();
        chk("t6_rst_wr_en", 64'(wr_en), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_addr", 64'(wr_addr), 64'd0);
        rst = 1'b0;
        repeat (5) tick();
        chk("t6_no_more", 64'(acc_cnt), 64'd10);
        reset_acc();
        send_line(8, 42, 31, 43, 0, -1, -1);
        wait_idle(200);
        repeat (2) tick();
        chk("t6_count", 64'(acc_cnt), 64'd40);
        chk("t6_first", 64'(acc_first), 64'd320);
        chk("t6_last", 64'(acc_last), 64'd359);

        for (int it = 0; it < 30; it++) begin
            row = ($urandom_range(0, 9) == 0) ? int'($urandom_range(ROWS, 1023))
                                              : int'($urandom_range(0, ROWS - 1));
            nb  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(25, 39))
                                              : int'($urandom_range(40, 46));
            g2p = int'($urandom_range(31, 36));
            g1p = int'($urandom_range(38, 52));
            lo  = -1;
            hi  = -1;
            if ($urandom_range(0, 9) == 0) begin
                lo = int'($urandom_range(2, 30));
                hi = lo + int'($urandom_range(0, 4));
            end
            ready_mode = int'($urandom_range(1, 3));
            send_line(row, nb, g2p, g1p, 1, lo, hi);
            if ($urandom_range(0, 3) != 0) wait_idle(400);
            repeat ($urandom_range(0, 3)) tick();
        end
        ready_mode = 1;
        wait_idle(400);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
